// File: rtl/uc_atende_fila_pkg.sv
// Shared definitions for the lift stop queue: default dimensions, state encoding
// and a small helper used to size counters.
package uc_atende_fila_pkg;

    localparam int N_ANDARES_DEF   = 8;
    localparam int ANDAR_W_DEF     = 3;
    localparam int TICKS_ANDAR_DEF = 4;
    localparam int TICKS_PORTA_DEF = 6;

    // Encoding is visible on the debug port, so the values are fixed.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_CARREGA  = 4'd1,
        ST_DECIDE   = 4'd2,
        ST_SOBE     = 4'd3,
        ST_DESCE    = 4'd4,
        ST_PASSO    = 4'd5,
        ST_PORTA    = 4'd6,
        ST_REMOVE   = 4'd7,
        ST_DESCARTA = 4'd8
    } estado_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uc_atende_fila_if.sv
// Queue head interface: the consumer (master) reads the head and requests pops;
// the queue (slave) presents the updated head on the cycle after a pop.
interface uc_atende_fila_if
    import uc_atende_fila_pkg::*;
#(
    parameter int ANDAR_W = ANDAR_W_DEF
);
    logic               fila_valida;
    logic [ANDAR_W-1:0] fila_andar;
    logic               pop;

    modport master (input fila_valida, input fila_andar, output pop);
    modport slave  (output fila_valida, output fila_andar, input pop);
endinterface

// File: rtl/uc_atende_fila_contador_timer.sv
// Tick counter with synchronous clear (priority over enable) and a terminal-count
// flag that is high while the count equals fim_valor.
module contador_timer
    import uc_atende_fila_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] fim_valor,
    output logic             fim
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fim = (cnt_q == fim_valor);

endmodule

// File: rtl/uc_atende_fila.sv
// Lift queue consumer: follows the queue head one floor at a time, opens the door
// at the stop and pops the entry. Optional PORTA_REABRE_EN adds a door-reopen button.
module uc_atende_fila
    import uc_atende_fila_pkg::*;
#(
    parameter int N_ANDARES   = N_ANDARES_DEF,
    parameter int ANDAR_W     = ANDAR_W_DEF,
    parameter int TICKS_ANDAR = TICKS_ANDAR_DEF,
    parameter int TICKS_PORTA = TICKS_PORTA_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               iniciar,
`ifdef PORTA_REABRE_EN
    input  logic               botao_porta,
`endif
    uc_atende_fila_if.master   fila,
    output logic [ANDAR_W-1:0] andar_atual,
    output logic               sobe,
    output logic               desce,
    output logic               porta_aberta,
    output logic               chegou,
    output logic               erro_andar,
    output logic [3:0]         Eatual_db
);
    localparam int CNT_W = $clog2(max_int(TICKS_ANDAR, TICKS_PORTA) + 1);
    localparam logic [ANDAR_W:0] N_LIM = (ANDAR_W + 1)'(N_ANDARES);

    estado_t            state_q, state_d;
    logic [ANDAR_W-1:0] andar_q;
    logic [ANDAR_W-1:0] alvo_q;
    logic               dir_sobe_q;
    logic               pop_q, sobe_q, desce_q, porta_q, chegou_q, erro_q;

    logic               botao;
    logic               t_en, t_clr, t_fim;
    logic [CNT_W-1:0]   t_fim_valor;

`ifdef PORTA_REABRE_EN
    assign botao = botao_porta;
`else
    assign botao = 1'b0;
`endif

    // One timer serves both movement and door; the terminal value follows the state.
    assign t_en        = (state_q == ST_SOBE) || (state_q == ST_DESCE) || (state_q == ST_PORTA);
    assign t_fim_valor = (state_q == ST_PORTA) ? CNT_W'(TICKS_PORTA - 1) : CNT_W'(TICKS_ANDAR - 1);
    assign t_clr       = (state_q == ST_CARREGA) || (t_en && t_fim) ||
                         ((state_q == ST_PORTA) && botao);

    contador_timer #(.CNT_W(CNT_W)) u_timer (
        .clock     (clock),
        .reset     (reset),
        .clr       (t_clr),
        .en        (t_en),
        .fim_valor (t_fim_valor),
        .fim       (t_fim)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (iniciar && fila.fila_valida) state_d = ST_CARREGA;
            ST_CARREGA:  state_d = ST_DECIDE;
            ST_DECIDE: begin
                if ({1'b0, alvo_q} >= N_LIM)  state_d = ST_DESCARTA;
                else if (alvo_q == andar_q)   state_d = ST_PORTA;
                else if (alvo_q > andar_q)    state_d = ST_SOBE;
                else                          state_d = ST_DESCE;
            end
            ST_SOBE,
            ST_DESCE:    if (t_fim) state_d = ST_PASSO;
            ST_PASSO:    state_d = ST_CARREGA;
            // A press on the last door cycle still wins: the door stays open.
            ST_PORTA:    if (t_fim && !botao) state_d = ST_REMOVE;
            ST_REMOVE,
            ST_DESCARTA: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            andar_q    <= '0;
            alvo_q     <= '0;
            dir_sobe_q <= 1'b0;
            pop_q      <= 1'b0;
            sobe_q     <= 1'b0;
            desce_q    <= 1'b0;
            porta_q    <= 1'b0;
            chegou_q   <= 1'b0;
            erro_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            // An empty head keeps the previous target.
            if ((state_q == ST_CARREGA) && fila.fila_valida) begin
                alvo_q <= fila.fila_andar;
            end
            if (state_q == ST_SOBE) begin
                dir_sobe_q <= 1'b1;
            end else if (state_q == ST_DESCE) begin
                dir_sobe_q <= 1'b0;
            end
            if (state_q == ST_PASSO) begin
                andar_q <= dir_sobe_q ? (andar_q + ANDAR_W'(1)) : (andar_q - ANDAR_W'(1));
            end
            pop_q    <= (state_d == ST_REMOVE) || (state_d == ST_DESCARTA);
            sobe_q   <= (state_d == ST_SOBE);
            desce_q  <= (state_d == ST_DESCE);
            porta_q  <= (state_d == ST_PORTA);
            chegou_q <= (state_d == ST_REMOVE);
            erro_q   <= (state_d == ST_DESCARTA);
        end
    end

    assign fila.pop     = pop_q;
    assign andar_atual  = andar_q;
    assign sobe         = sobe_q;
    assign desce        = desce_q;
    assign porta_aberta = porta_q;
    assign chegou       = chegou_q;
    assign erro_andar   = erro_q;
    assign Eatual_db    = state_q;

endmodule

// File: tb/tb_uc_atende_fila.sv
// Directed bench for uc_atende_fila: a table of full services from a known floor,
// plus hand sequences for head change mid-move, reset in the door, iniciar drop, reopen.
module tb_uc_atende_fila;

    logic       clock;
    logic       reset;
    logic       iniciar;
`ifdef PORTA_REABRE_EN
    logic       botao_porta;
`endif
    logic [3:0] andar_atual;
    logic       sobe, desce, porta_aberta, chegou, erro_andar;
    logic [3:0] Eatual_db;

    uc_atende_fila_if #(.ANDAR_W(4)) fila_if ();

    uc_atende_fila #(
        .N_ANDARES   (8),
        .ANDAR_W     (4),
        .TICKS_ANDAR (4),
        .TICKS_PORTA (6)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
`ifdef PORTA_REABRE_EN
        .botao_porta  (botao_porta),
`endif
        .fila         (fila_if),
        .andar_atual  (andar_atual),
        .sobe         (sobe),
        .desce        (desce),
        .porta_aberta (porta_aberta),
        .chegou       (chegou),
        .erro_andar   (erro_andar),
        .Eatual_db    (Eatual_db)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] head;
        int         exp_cyc;
        int         exp_sobe;
        int         exp_desce;
        int         exp_porta;
        int         exp_chegou;
        int         exp_erro;
        int         exp_andar;
    } vec_t;

    vec_t tab [10];

    int checks = 0;
    int errors = 0;

    int r_cyc, r_sobe, r_desce, r_porta, r_chegou, r_erro, r_pop, r_low_desce;
    bit r_done;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Runs one service from IDLE until the pop (bounded), then idles 3 cycles.
    task automatic run_service(input logic [3:0] head, input bit chg_en,
                               input logic [3:0] chg_head, input int drop_at,
                               input int low_floor);
        r_cyc = 0; r_sobe = 0; r_desce = 0; r_porta = 0;
        r_chegou = 0; r_erro = 0; r_pop = 0; r_low_desce = 0; r_done = 0;
        fila_if.fila_andar  = head;
        fila_if.fila_valida = 1'b1;
        iniciar             = 1'b1;
        while (!r_done && r_cyc < 300) begin
            tick();
            r_cyc++;
            if (drop_at == r_cyc) iniciar = 1'b0;
            if (chg_en && Eatual_db == 4'd4) fila_if.fila_andar = chg_head;
            r_sobe   += int'(sobe);
            r_desce  += int'(desce);
            r_porta  += int'(porta_aberta);
            r_chegou += int'(chegou);
            r_erro   += int'(erro_andar);
            if (desce && int'(andar_atual) <= low_floor) r_low_desce++;
            if (fila_if.pop) begin
                r_pop++;
                r_done = 1;
            end
        end
        iniciar             = 1'b0;
        fila_if.fila_valida = 1'b0;
        if (!r_done) begin
            checks++;
            errors++;
            $display("FAIL timeout: no pop within %0d cycles, head %0d", r_cyc, head);
        end
        repeat (3) begin
            tick();
            r_pop    += int'(fila_if.pop);
            r_chegou += int'(chegou);
            r_erro   += int'(erro_andar);
        end
    endtask

    initial begin
        // Floor sequence 0->5->5->(9)->2->7->0->(15)->(8)->7->6; 9 + 7 cycles per floor.
        tab[0] = '{4'd5,  44, 20,  0, 6, 1, 0, 5};
        tab[1] = '{4'd5,   9,  0,  0, 6, 1, 0, 5};
        tab[2] = '{4'd9,   3,  0,  0, 0, 0, 1, 5};
        tab[3] = '{4'd2,  30,  0, 12, 6, 1, 0, 2};
        tab[4] = '{4'd7,  44, 20,  0, 6, 1, 0, 7};
        tab[5] = '{4'd0,  58,  0, 28, 6, 1, 0, 0};
        tab[6] = '{4'd15,  3,  0,  0, 0, 0, 1, 0};
        tab[7] = '{4'd8,   3,  0,  0, 0, 0, 1, 0};
        tab[8] = '{4'd7,  58, 28,  0, 6, 1, 0, 7};
        tab[9] = '{4'd6,  16,  0,  4, 6, 1, 0, 6};

        reset               = 1'b1;
        iniciar             = 1'b0;
        fila_if.fila_valida = 1'b0;
        fila_if.fila_andar  = '0;
`ifdef PORTA_REABRE_EN
        botao_porta         = 1'b0;
`endif
        repeat (3) tick();
        chk("reset_state", int'(Eatual_db), 0);
        chk("reset_andar", int'(andar_atual), 0);
        chk("reset_outs", int'({fila_if.pop, sobe, desce, porta_aberta, chegou, erro_andar}), 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_service(tab[i].head, 1'b0, 4'd0, 0, -1);
            $display("vec %0d head %0d: cyc %0d sobe %0d desce %0d porta %0d chegou %0d erro %0d andar %0d",
                     i, tab[i].head, r_cyc, r_sobe, r_desce, r_porta, r_chegou, r_erro, andar_atual);
            chk("vec_cycles", r_cyc, tab[i].exp_cyc);
            chk("vec_sobe", r_sobe, tab[i].exp_sobe);
            chk("vec_desce", r_desce, tab[i].exp_desce);
            chk("vec_porta", r_porta, tab[i].exp_porta);
            chk("vec_chegou", r_chegou, tab[i].exp_chegou);
            chk("vec_erro", r_erro, tab[i].exp_erro);
            chk("vec_andar", int'(andar_atual), tab[i].exp_andar);
            chk("vec_pop", r_pop, 1);
            chk("vec_idle", int'(Eatual_db), 0);
        end

        // Car at 6 heading for 2; head becomes 4 while descending.
        run_service(4'd2, 1'b1, 4'd4, 0, 4);
        $display("head change 2->4: cyc %0d desce %0d pop %0d andar %0d", r_cyc, r_desce, r_pop, andar_atual);
        chk("chg_andar", int'(andar_atual), 4);
        chk("chg_pop", r_pop, 1);
        chk("chg_cycles", r_cyc, 23);
        chk("chg_desce", r_desce, 8);
        chk("chg_low_desce", r_low_desce, 0);

        // Reset while the door is open at floor 3.
        begin
            int w = 0;
            fila_if.fila_andar  = 4'd3;
            fila_if.fila_valida = 1'b1;
            iniciar             = 1'b1;
            while (!porta_aberta && w < 100) begin
                tick();
                w++;
            end
            if (!porta_aberta) begin
                checks++;
                errors++;
                $display("FAIL timeout: door never opened at floor 3");
            end
            tick();
            chk("rst_pre_andar", int'(andar_atual), 3);
            reset = 1'b1;
            tick();
            $display("reset in door: state %0d andar %0d porta %0d pop %0d",
                     Eatual_db, andar_atual, porta_aberta, fila_if.pop);
            chk("rst_state", int'(Eatual_db), 0);
            chk("rst_andar", int'(andar_atual), 0);
            chk("rst_porta", int'(porta_aberta), 0);
            chk("rst_pop", int'(fila_if.pop), 0);
            reset               = 1'b0;
            iniciar             = 1'b0;
            fila_if.fila_valida = 1'b0;
            tick();
        end

        // iniciar dropped mid-service: service completes, then the block waits.
        run_service(4'd2, 1'b0, 4'd0, 2, -1);
        $display("iniciar drop: cyc %0d chegou %0d andar %0d", r_cyc, r_chegou, andar_atual);
        chk("drop_cycles", r_cyc, 23);
        chk("drop_chegou", r_chegou, 1);
        chk("drop_andar", int'(andar_atual), 2);
        begin
            int busy = 0;
            fila_if.fila_andar  = 4'd6;
            fila_if.fila_valida = 1'b1;
            repeat (10) begin
                tick();
                if (Eatual_db != 4'd0 || fila_if.pop) busy++;
            end
            fila_if.fila_valida = 1'b0;
            $display("idle wait with iniciar low: busy cycles %0d", busy);
            chk("drop_wait_idle", busy, 0);
        end

`ifdef PORTA_REABRE_EN
        // Door button pressed in door cycle 4: door open 4 + 6 cycles.
        begin
            int cyc = 0;
            int porta_n = 0;
            bit done = 0;
            fila_if.fila_andar  = 4'd2;
            fila_if.fila_valida = 1'b1;
            iniciar             = 1'b1;
            while (!done && cyc < 100) begin
                tick();
                cyc++;
                botao_porta = 1'b0;
                if (porta_aberta) begin
                    porta_n++;
                    if (porta_n == 4) botao_porta = 1'b1;
                end
                if (fila_if.pop) done = 1;
            end
            botao_porta         = 1'b0;
            iniciar             = 1'b0;
            fila_if.fila_valida = 1'b0;
            $display("door reopen: porta %0d cyc %0d", porta_n, cyc);
            chk("reabre_porta", porta_n, 10);
            chk("reabre_cycles", cyc, 13);
            tick();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
